// File: rtl/shifter_pkg.sv
// shifter_pkg: op encodings and the per-stage split of shifter layers
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b011,
        OP_ROL = 3'b100,
        OP_ROR = 3'b101
    } op_e;

    // Earlier stages absorb the remainder when lg does not divide evenly
    function automatic int layer_count(int lg, int stages, int s);
        return lg / stages + ((s < lg % stages) ? 1 : 0);
    endfunction

    function automatic int layer_first(int lg, int stages, int s);
        int f = 0;
        for (int i = 0; i < s; i++) f += layer_count(lg, stages, i);
        return f;
    endfunction

endpackage

// File: rtl/shifter_if.sv
// shifter_if: request/response handshake bundle for shifter_pipe
interface shifter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [XLEN-1:0]  operand_a;
    logic [XLEN-1:0]  operand_b;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, op, operand_a, operand_b, tag_in, out_ready,
        input  in_ready, out_valid, result, tag_out
    );

    modport slave (
        input  in_valid, op, operand_a, operand_b, tag_in, out_ready,
        output in_ready, out_valid, result, tag_out
    );
endinterface

// File: rtl/shifter_stage.sv
// shifter_stage: COUNT right-shift/rotate layers starting at layer FIRST, then an enabled pipeline register
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int LG    = $clog2(XLEN),
    parameter int FIRST = 0,
    parameter int COUNT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid,
    input  logic [XLEN-1:0]  data,
    input  logic             fill,
    input  logic [LG-1:0]    sh,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] tag,
    output logic             valid_q,
    output logic [XLEN-1:0]  data_q,
    output logic             fill_q,
    output logic [LG-1:0]    sh_q,
    output logic [2:0]       op_q,
    output logic [TAG_W-1:0] tag_q
);
    logic            rot;
    logic [XLEN-1:0] d [COUNT+1];

    assign rot  = op == OP_ROL || op == OP_ROR;
    assign d[0] = data;

    // Layer order is MSB first: layer index j shifts by 2^(LG-1-j)
    for (genvar g = 0; g < COUNT; g++) begin : g_layer
        localparam int K = LG - 1 - FIRST - g;
        localparam int A = 1 << K;
        assign d[g+1] = !sh[K] ? d[g] :
                        rot    ? {d[g][A-1:0], d[g][XLEN-1:A]} :
                                 {{A{fill}}, d[g][XLEN-1:A]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            fill_q  <= 1'b0;
            sh_q    <= '0;
            op_q    <= '0;
            tag_q   <= '0;
        end else if (en) begin
            valid_q <= valid;
            data_q  <= d[COUNT];
            fill_q  <= fill;
            sh_q    <= sh;
            op_q    <= op;
            tag_q   <= tag;
        end
    end
endmodule

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter; left ops run as bit-reversed right shifts
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic     clk,
    input  logic     rst,
    shifter_if.slave bus
);
    localparam int LG = $clog2(XLEN);

    logic                        en;
    logic                        legal;
    logic                        left_in;
    logic                        left_out;
    logic [XLEN-1:0]             a_rev;
    logic [XLEN-1:0]             d_rev;
    logic                        unused_b;
    logic [STAGES:0]             v;
    logic [STAGES:0]             f;
    logic [STAGES:0][XLEN-1:0]   d;
    logic [STAGES:0][LG-1:0]     sh;
    logic [STAGES:0][2:0]        op;
    logic [STAGES:0][TAG_W-1:0]  tg;

    assign en           = ~v[STAGES] | bus.out_ready;
    assign bus.in_ready = en;

    // Reserved ops travel with a zero shift so they pass operand_a through
    assign legal   = bus.op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
    assign left_in = bus.op == OP_SLL || bus.op == OP_ROL;
    assign a_rev   = {<<{bus.operand_a}};

    assign v[0]  = bus.in_valid;
    assign d[0]  = left_in ? a_rev : bus.operand_a;
    assign f[0]  = bus.op == OP_SRA && bus.operand_a[XLEN-1];
    assign sh[0] = legal ? bus.operand_b[LG-1:0] : '0;
    assign op[0] = bus.op;
    assign tg[0] = bus.tag_in;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        shifter_stage #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W),
            .LG    (LG),
            .FIRST (layer_first(LG, STAGES, i)),
            .COUNT (layer_count(LG, STAGES, i))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .valid   (v[i]),
            .data    (d[i]),
            .fill    (f[i]),
            .sh      (sh[i]),
            .op      (op[i]),
            .tag     (tg[i]),
            .valid_q (v[i+1]),
            .data_q  (d[i+1]),
            .fill_q  (f[i+1]),
            .sh_q    (sh[i+1]),
            .op_q    (op[i+1]),
            .tag_q   (tg[i+1])
        );
    end

    assign left_out      = op[STAGES] == OP_SLL || op[STAGES] == OP_ROL;
    assign d_rev         = {<<{d[STAGES]}};
    assign bus.result    = left_out ? d_rev : d[STAGES];
    assign bus.tag_out   = tg[STAGES];
    assign bus.out_valid = v[STAGES];
    assign unused_b      = ^{bus.operand_b[XLEN-1:LG], sh[STAGES], f[STAGES]};
endmodule
